// File: rtl/e203_biu_icb_arbt_pkg.sv
// rtl/e203_biu_icb_arbt_pkg.sv - shared e203 defines: source IDs and arbiter defaults
package e203_biu_icb_arbt_pkg;

  typedef enum logic {
    SRC_IFU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  localparam int OTF_DP_DEF     = 2;
  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/e203_biu_icb_arbt_if.sv
// rtl/e203_biu_icb_arbt_if.sv - ICB command/response bundle with master/slave views
interface e203_biu_icb_arbt_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_read;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );

  // Fetch-only requester: no write fields, the arbiter forces read semantics
  modport rd_slave (
    input  cmd_valid, cmd_addr, rsp_ready,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );

endinterface

// File: rtl/sirv_gnrl_fifo.sv
// rtl/sirv_gnrl_fifo.sv - small synchronous FIFO holding response-routing source IDs
module sirv_gnrl_fifo #(
  parameter int DP = 2,
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_dat,
  input  logic          i_pop,
  output logic [DW-1:0] o_pop_dat,
  output logic          o_full,
  output logic          o_empty
);

  localparam int PW = (DP > 1) ? $clog2(DP) : 1;
  localparam int CW = $clog2(DP + 1);

  logic [DW-1:0] r_mem [DP];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          w_push;
  logic          w_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DP - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_full    = (r_cnt == CW'(DP));
  assign o_empty   = (r_cnt == '0);
  assign w_push    = i_push & ~o_full;
  assign w_pop     = i_pop & ~o_empty;
  assign o_pop_dat = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= next_ptr(r_wptr);
      if (w_pop)  r_rptr <= next_ptr(r_rptr);
      if (w_push && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (w_pop && !w_push) r_cnt <= r_cnt - CW'(1);
    end
  end

  // Storage needs no reset: entries are only read while counted valid
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_dat;
  end

endmodule

// File: rtl/e203_biu_icb_arbt.sv
// rtl/e203_biu_icb_arbt.sv - IFU/LSU to BIU ICB arbiter with starvation guard and in-order response routing
module e203_biu_icb_arbt
  import e203_biu_icb_arbt_pkg::*;
#(
  parameter int OTF_DP     = OTF_DP_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  e203_biu_icb_arbt_if.rd_slave   i_ifu,
  e203_biu_icb_arbt_if.slave      i_lsu,
  e203_biu_icb_arbt_if.master     o_biu
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [SW-1:0] r_starve;
  logic          r_lock;
  logic          r_lock_src;

  logic          w_starved;
  logic          w_sel_lsu;
  logic          w_cmd_hs;
  logic          w_rsp_hs;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_head;
  logic          w_head_lsu;

  assign w_starved = (r_starve == SW'(STARVE_MAX));

  // LSU wins by default; a starved IFU takes over; a stalled command keeps its grant
  assign w_sel_lsu = r_lock ? r_lock_src
                            : (i_lsu.cmd_valid & ~(i_ifu.cmd_valid & w_starved));

  assign o_biu.cmd_valid = ~w_fifo_full & (w_sel_lsu ? i_lsu.cmd_valid : i_ifu.cmd_valid);
  assign o_biu.cmd_addr  = w_sel_lsu ? i_lsu.cmd_addr  : i_ifu.cmd_addr;
  assign o_biu.cmd_read  = w_sel_lsu ? i_lsu.cmd_read  : 1'b1;
  assign o_biu.cmd_wdata = w_sel_lsu ? i_lsu.cmd_wdata : 32'h0;
  assign o_biu.cmd_wmask = w_sel_lsu ? i_lsu.cmd_wmask : 4'h0;

  assign i_ifu.cmd_ready = ~w_sel_lsu & o_biu.cmd_ready & ~w_fifo_full;
  assign i_lsu.cmd_ready =  w_sel_lsu & o_biu.cmd_ready & ~w_fifo_full;

  assign w_cmd_hs = o_biu.cmd_valid & o_biu.cmd_ready;

  assign w_head_lsu      = ~w_fifo_empty & (w_head == logic'(SRC_LSU));
  assign i_ifu.rsp_valid = ~w_fifo_empty & ~w_head_lsu & o_biu.rsp_valid;
  assign i_lsu.rsp_valid = w_head_lsu & o_biu.rsp_valid;
  assign i_ifu.rsp_err   = o_biu.rsp_err;
  assign i_lsu.rsp_err   = o_biu.rsp_err;
  assign i_ifu.rsp_rdata = o_biu.rsp_rdata;
  assign i_lsu.rsp_rdata = o_biu.rsp_rdata;
  assign o_biu.rsp_ready = ~w_fifo_empty & (w_head_lsu ? i_lsu.rsp_ready : i_ifu.rsp_ready);

  assign w_rsp_hs = o_biu.rsp_valid & o_biu.rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve   <= '0;
      r_lock     <= 1'b0;
      r_lock_src <= 1'b0;
    end else begin
      r_lock     <= o_biu.cmd_valid & ~o_biu.cmd_ready;
      r_lock_src <= w_sel_lsu;
      if (w_cmd_hs) begin
        if (!w_sel_lsu)
          r_starve <= '0;
        else if (i_ifu.cmd_valid && !w_starved)
          r_starve <= r_starve + SW'(1);
      end
    end
  end

  sirv_gnrl_fifo #(
    .DP (OTF_DP),
    .DW (1)
  ) u_rsp_route_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_cmd_hs),
    .i_push_dat (w_sel_lsu),
    .i_pop      (w_rsp_hs),
    .o_pop_dat  (w_head),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

endmodule

// File: doc/e203_biu_icb_arbt.md
E203_BIU_ICB_ARBT -- requirements
Module: e203_biu_icb_arbt

Interface
REQ-001 SHALL have parameter OTF_DP, default 2: maximum outstanding commands (response-routing FIFO depth).
REQ-002 SHALL have parameter STARVE_MAX, default 4: maximum consecutive LSU grants while IFU waits.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 ifu_icb_cmd_valid/ready  in/out  1/1  IFU read command handshake.
REQ-006 ifu_icb_cmd_addr  in  32  IFU fetch address.
REQ-007 ifu_icb_rsp_valid/ready  out/in  1/1  IFU response handshake.
REQ-008 ifu_icb_rsp_err, ifu_icb_rsp_rdata  out  1, 32  IFU response error and data.
REQ-009 lsu_icb_cmd_valid/ready  in/out  1/1  LSU command handshake.
REQ-010 lsu_icb_cmd_addr, lsu_icb_cmd_read, lsu_icb_cmd_wdata, lsu_icb_cmd_wmask  in  32, 1, 32, 4  LSU command fields.
REQ-011 lsu_icb_rsp_valid/ready  out/in  1/1  LSU response handshake.
REQ-012 lsu_icb_rsp_err, lsu_icb_rsp_rdata  out  1, 32  LSU response error and data.
REQ-013 biu_icb_cmd_valid/ready  out/in  1/1  merged command to BIU.
REQ-014 biu_icb_cmd_addr, biu_icb_cmd_read, biu_icb_cmd_wdata, biu_icb_cmd_wmask  out  32, 1, 32, 4  merged command fields.
REQ-015 biu_icb_rsp_valid/ready  in/out  1/1  BIU response handshake.
REQ-016 biu_icb_rsp_err, biu_icb_rsp_rdata  in  1, 32  BIU response error and data.

Function
REQ-017 Arbitration SHALL use fixed LSU priority, overridden per REQ-018 and REQ-019.
REQ-018 The starve counter SHALL count LSU grants made while ifu_icb_cmd_valid=1, SHALL clear on any IFU grant, and SHALL saturate at STARVE_MAX.
REQ-019 With the starve counter at STARVE_MAX and both requesters valid, IFU SHALL win.
REQ-020 Once biu_icb_cmd_valid=1 without ready, the grant SHALL be locked until the command handshakes, so the command is stable and not re-arbitrated (lock flop).
REQ-021 IFU commands SHALL drive biu_icb_cmd_read=1, wdata=0 and wmask=0.
REQ-022 Only the granted requester SHALL see cmd_ready = biu_icb_cmd_ready & ~fifo_full; the other requester SHALL see cmd_ready=0.
REQ-023 biu_icb_cmd_valid SHALL be 0 while the routing FIFO is full, even if a pop occurs in the same cycle.
REQ-024 Each BIU command handshake SHALL push its source ID (0=IFU, 1=LSU) into the routing FIFO.
REQ-025 Responses SHALL be in order: the FIFO head SHALL steer biu_icb_rsp_valid/err/rdata to that port, and biu_icb_rsp_ready SHALL be the steered port's rsp_ready.
REQ-026 A response handshake SHALL pop the FIFO, and a push and a pop in the same cycle SHALL leave the count unchanged.
REQ-027 With the FIFO empty, biu_icb_rsp_ready=0 and both rsp_valid outputs SHALL be 0.
REQ-028 Command path latency SHALL be zero cycles (combinational), and response path latency SHALL be zero cycles.
REQ-029 A response SHALL be routable in the same cycle as a new command issue.

Reset
REQ-030 While rst=1, the FIFO SHALL empty, the starve counter SHALL clear and the lock SHALL clear on the next clk edge.
REQ-031 In the cycle after reset all valid/ready outputs SHALL be 0, except: cmd_ready per REQ-022, and biu_icb_rsp_ready=0 because the FIFO is empty.
REQ-032 Reset asserted mid-transaction SHALL discard all outstanding routing state; the BIU is reset in the same domain.

Structure
REQ-033 Source ID encodings and default OTF_DP/STARVE_MAX SHALL live in the shared e203 defines package.
REQ-034 The routing FIFO SHALL be the sub-module sirv_gnrl_fifo (DP=OTF_DP, DW=1), instantiated once; arbitration and lock logic SHALL be local.

Verification
REQ-035 IFU only, addr 0x8000_0000, BIU ready -> biu addr 0x8000_0000, read=1; response rdata 0x0000_0013 arrives on the IFU port only.
REQ-036 Both valid continuously, ready=1, responses immediate -> grant order LSU x4, IFU, LSU x4, IFU.
REQ-037 LSU write (wmask 0xF) with biu_icb_cmd_ready low for 3 cycles while IFU asserts -> command stable for 3 cycles, LSU granted, IFU ready=0.
REQ-038 Two commands issued (IFU then LSU) with responses withheld -> third request blocked (FIFO full); responses return to IFU then LSU in order.
REQ-039 BIU rsp err=1 on an LSU-tagged response -> lsu_icb_rsp_err=1 and ifu_icb_rsp_valid=0.
REQ-040 rst=1 for 1 cycle with 2 outstanding -> FIFO empty afterwards, biu_icb_rsp_ready=0, and the next IFU command issues normally.
